// File: rtl/data_synchronizer_pkg.sv
// Shared constants and elaboration-time parameter checks for data_synchronizer.
package data_synchronizer_pkg;

  localparam int ENABLE_MODE_LEVEL  = 0;
  localparam int ENABLE_MODE_TOGGLE = 1;

  function automatic bit params_legal(input int stage_count, input int bus_width,
                                      input int enable_mode);
    return (stage_count >= 2) && (bus_width >= 1) &&
           ((enable_mode == ENABLE_MODE_LEVEL) || (enable_mode == ENABLE_MODE_TOGGLE));
  endfunction

endpackage

// File: rtl/bus_synchronizer.sv
// Register-chain synchronizer: each bit of d_i passes through STAGE_COUNT flops.
// Latency STAGE_COUNT clk edges; no backpressure.
module bus_synchronizer #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] d_i,
  output logic [BUS_WIDTH-1:0] q_o
);

  logic [STAGE_COUNT-1:0][BUS_WIDTH-1:0] sync_q;
  logic [STAGE_COUNT-1:0][BUS_WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGE_COUNT-2:0], d_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGE_COUNT-1];

endmodule

// File: rtl/pulse_generator.sv
// Edge detector on an already-synchronized level: rising edge (level mode) or any edge (toggle mode).
// Pulse is combinational from level_in and the registered history bit; no backpressure.
module pulse_generator
  import data_synchronizer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  input  logic mode,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_in;
    end
  end

  always_comb begin
    if (mode == 1'(ENABLE_MODE_TOGGLE)) begin
      pulse = level_in ^ prev_q;
    end else begin
      pulse = level_in & ~prev_q;
    end
  end

endmodule

// File: rtl/data_synchronizer.sv
// Enable-qualified bus CDC: only the enable is synchronized; the bus is captured on the resulting pulse.
// Latency STAGE_COUNT+1 edges from enable sampling; no handshake. Optional DATA_SYNCHRONIZER_STABILITY_CHECK_EN.
module data_synchronizer
  import data_synchronizer_pkg::*;
#(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int ENABLE_MODE = ENABLE_MODE_LEVEL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] asynchronous_data,
  input  logic                 asynchronous_enable,
  output logic [BUS_WIDTH-1:0] synchronous_data,
  output logic                 synchronous_enable
`ifdef DATA_SYNCHRONIZER_STABILITY_CHECK_EN
  ,
  output logic                 data_unstable
`endif
);

  if (!params_legal(STAGE_COUNT, BUS_WIDTH, ENABLE_MODE)) begin : g_bad_params
    $error("data_synchronizer: illegal STAGE_COUNT/BUS_WIDTH/ENABLE_MODE");
  end

  logic                 en_sync;
  logic                 evt;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 pulse_q, pulse_d;

  bus_synchronizer #(
    .STAGE_COUNT (STAGE_COUNT),
    .BUS_WIDTH   (1)
  ) u_en_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (asynchronous_enable),
    .q_o   (en_sync)
  );

  pulse_generator u_pulse (
    .clk      (clk),
    .reset    (reset),
    .level_in (en_sync),
    .mode     (1'(ENABLE_MODE)),
    .pulse    (evt)
  );

  // The source guarantees the bus is stable around the event, so it is safe to sample here.
  always_comb begin
    pulse_d = evt;
    data_d  = evt ? asynchronous_data : data_q;
  end

`ifdef DATA_SYNCHRONIZER_STABILITY_CHECK_EN
  logic chk_q, chk_d;
  logic unstable_q, unstable_d;

  always_comb begin
    chk_d      = evt;
    unstable_d = unstable_q | (chk_q & (asynchronous_data != data_q));
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      pulse_q    <= 1'b0;
`ifdef DATA_SYNCHRONIZER_STABILITY_CHECK_EN
      chk_q      <= 1'b0;
      unstable_q <= 1'b0;
`endif
    end else begin
      data_q     <= data_d;
      pulse_q    <= pulse_d;
`ifdef DATA_SYNCHRONIZER_STABILITY_CHECK_EN
      chk_q      <= chk_d;
      unstable_q <= unstable_d;
`endif
    end
  end

  assign synchronous_data   = data_q;
  assign synchronous_enable = pulse_q;
`ifdef DATA_SYNCHRONIZER_STABILITY_CHECK_EN
  assign data_unstable      = unstable_q;
`endif

endmodule
